// File: rtl/poly_cal_pkg.sv
// poly_cal_pkg
// Shared types and saturating arithmetic for the polynomial calibration
// datapath. Arithmetic helpers work on a 64-bit signed intermediate so one
// set of functions serves any datapath width up to 32 bits; the width and
// fraction count are passed in as arguments.
package poly_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MULT,
    ADD,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_ADD  = 1'b1
  } alu_op_t;

  localparam int CALC_W = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    logic [CALC_W-1:0] y;
    logic              sat;
  } sat_res_t;

  // Largest positive value of a w-bit two's complement operand.
  function automatic calc_t sat_max(input int w);
    return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
  endfunction

  // Most negative value of a w-bit two's complement operand.
  function automatic calc_t sat_min(input int w);
    return -(calc_t'(1) <<< (w - 1));
  endfunction

  function automatic sat_res_t clamp(input calc_t v, input int w);
    sat_res_t r;
    r.y   = v;
    r.sat = 1'b0;
    if (v > sat_max(w)) begin
      r.y   = sat_max(w);
      r.sat = 1'b1;
    end else if (v < sat_min(w)) begin
      r.y   = sat_min(w);
      r.sat = 1'b1;
    end
    return r;
  endfunction

  // Operands must already be sign-extended to CALC_W.
  function automatic sat_res_t sat_add(input calc_t a, input calc_t b, input int w);
    return clamp(a + b, w);
  endfunction

  // Full-precision product, then drop the fraction bits (arithmetic shift,
  // i.e. rounds toward minus infinity) before clamping.
  function automatic sat_res_t sat_mult(input calc_t a, input calc_t b, input int w,
                                        input int frac);
    calc_t p;
    p = a * b;
    return clamp(p >>> frac, w);
  endfunction

endpackage

// File: rtl/sat_alu_p.sv
// sat_alu_p
// Combinational saturating ALU shared by the MULT and ADD steps.
// Ports:
//   a, b  in  WIDTH  signed operands (a = working value, b = X or C)
//   op    in  1      0 = fixed-point multiply (Q.FRAC), 1 = add
//   y     out WIDTH  clamped result
//   sat   out 1      the clamp fired for this operation
module sat_alu_p
  import poly_cal_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  calc_t    a_ext;
  calc_t    b_ext;
  sat_res_t res;

  always_comb begin
    a_ext = calc_t'($signed(a));
    b_ext = calc_t'($signed(b));
    if (alu_op_t'(op) == OP_ADD) begin
      res = sat_add(a_ext, b_ext, WIDTH);
    end else begin
      res = sat_mult(a_ext, b_ext, WIDTH, FRAC);
    end
  end

  // The clamp guarantees the upper bits are pure sign extension.
  assign y   = WIDTH'(res.y);
  assign sat = res.sat;

endmodule

// File: rtl/poly_cal_datapath.sv
// poly_cal_datapath
// Evaluates a signed fixed-point calibration polynomial on one A2D sample by
// Horner's rule: p = c[ORDER]; p = sat(sat(p*x) + c[k]) for k = ORDER-1..0.
// Coefficients are fetched one at a time over a req/vld handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin evaluation (only honoured in IDLE)
//   a2d          sample x, captured on an accepted start
//   coeff_req    coefficient read request (high for the whole FETCH)
//   coeff_addr   address of the requested coefficient
//   coeff_vld    acknowledge for the current request
//   coeff        coefficient data, taken when coeff_vld and coeff_req
//   busy         evaluation in progress (FETCH/MULT/ADD)
//   done         one-cycle pulse, dst valid
//   dst          result register, holds until the next done
//   sat_flag     sticky: some clamp fired during the current run
module poly_cal_datapath
  import poly_cal_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int ORDER = 2,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a2d,
  output logic             coeff_req,
  output logic [AW-1:0]    coeff_addr,
  input  logic             coeff_vld,
  input  logic [WIDTH-1:0] coeff,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dst,
  output logic             sat_flag
);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic             sat_q, sat_d;

  logic             alu_op;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_sat;

  // One ALU serves both steps: ADD combines with C, MULT scales by X.
  assign alu_op = (state_q == ADD);
  assign alu_b  = alu_op ? c_q : x_q;

  sat_alu_p #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_alu (
    .a  (temp_q),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y),
    .sat(alu_sat)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: the default assignment first means every path assigns state_d,
  // so no latch is inferred for the paths that do not change state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      // The highest coefficient only seeds Temp, so it is followed straight
      // by the next fetch rather than by a multiply.
      FETCH:   if (coeff_vld && addr_q != AW'(ORDER)) state_d = MULT;
      MULT:    state_d = ADD;
      ADD:     state_d = (addr_q == '0) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    coeff_req = (state_q == FETCH);
    busy      = (state_q == FETCH) || (state_q == MULT) || (state_q == ADD);
    done      = (state_q == DONE);
  end

  assign coeff_addr = addr_q;
  assign dst        = dst_q;
  assign sat_flag   = sat_q;

  // Datapath register updates.
  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    c_d    = c_q;
    temp_d = temp_q;
    dst_d  = dst_q;
    sat_d  = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = AW'(ORDER);
          x_d    = a2d;
          sat_d  = 1'b0;
        end
      end
      FETCH: begin
        if (coeff_vld) begin
          c_d = coeff;
          if (addr_q == AW'(ORDER)) begin
            temp_d = coeff;
            addr_d = addr_q - AW'(1);
          end
        end
      end
      MULT: begin
        temp_d = alu_y;
        sat_d  = sat_q | alu_sat;
      end
      ADD: begin
        temp_d = alu_y;
        sat_d  = sat_q | alu_sat;
        // dst is loaded with the final sum so it is already valid while
        // done is high.
        if (addr_q == '0) dst_d = alu_y;
        else              addr_d = addr_q - AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      x_q    <= '0;
      c_q    <= '0;
      temp_q <= '0;
      dst_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      x_q    <= x_d;
      c_q    <= c_d;
      temp_q <= temp_d;
      dst_q  <= dst_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: tb/tb_poly_cal_datapath.sv
// tb_poly_cal_datapath
// Directed bench for poly_cal_datapath (WIDTH=16, FRAC=12, ORDER=2).
// A behavioural Horner model gives the expected result of each run; a
// memory process answers coefficient requests with a programmable delay;
// a compare process checks done/busy/dst/sat_flag every cycle.
module tb_poly_cal_datapath;

  localparam int WIDTH = 16;
  localparam int FRAC  = 12;
  localparam int ORDER = 2;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a2d = '0;
  logic             coeff_req;
  logic [AW-1:0]    coeff_addr;
  logic             coeff_vld = 1'b0;
  logic [WIDTH-1:0] coeff = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dst;
  logic             sat_flag;

  poly_cal_datapath #(
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .ORDER(ORDER),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a2d       (a2d),
    .coeff_req (coeff_req),
    .coeff_addr(coeff_addr),
    .coeff_vld (coeff_vld),
    .coeff     (coeff),
    .busy      (busy),
    .done      (done),
    .dst       (dst),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [WIDTH-1:0] y;
    bit               sat;
  } model_t;

  function automatic model_t poly_model(input logic [WIDTH-1:0] c [0:ORDER],
                                        input logic [WIDTH-1:0] x);
    longint hi;
    longint lo;
    longint p;
    longint xv;
    model_t r;
    hi    = (longint'(1) << (WIDTH - 1)) - 1;
    lo    = -(longint'(1) << (WIDTH - 1));
    xv    = longint'($signed(x));
    p     = longint'($signed(c[ORDER]));
    r.sat = 1'b0;
    for (int k = ORDER - 1; k >= 0; k--) begin
      p = (p * xv) >>> FRAC;
      if (p > hi) begin p = hi; r.sat = 1'b1; end
      else if (p < lo) begin p = lo; r.sat = 1'b1; end
      p = p + longint'($signed(c[k]));
      if (p > hi) begin p = hi; r.sat = 1'b1; end
      else if (p < lo) begin p = lo; r.sat = 1'b1; end
    end
    r.y = p[WIDTH-1:0];
    return r;
  endfunction

  // ---------------- coefficient memory ----------------
  logic [WIDTH-1:0] mem [0:ORDER];
  int               mem_wait = 1;
  bit               stray = 1'b0;
  logic [AW-1:0]    addr_log [$];

  initial begin
    bit            prev_req;
    bit            prev_vld;
    logic [AW-1:0] prev_addr;
    int            cnt;
    prev_req  = 1'b0;
    prev_vld  = 1'b0;
    prev_addr = '0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (coeff_req === 1'b1) begin
        // A request still waiting for its vld must keep its address.
        if (prev_req && !prev_vld) check("addr_stable", 32'(coeff_addr), 32'(prev_addr));
        if (!prev_req || prev_vld) cnt = 0;
        else                       cnt++;
        coeff_vld = (cnt >= mem_wait);
        coeff     = (coeff_addr <= AW'(ORDER)) ? mem[coeff_addr] : 16'hDEAD;
        if (coeff_vld) addr_log.push_back(coeff_addr);
      end else begin
        cnt       = 0;
        coeff_vld = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        coeff     = 16'($urandom);
      end
      prev_req  = (coeff_req === 1'b1);
      prev_vld  = coeff_vld;
      prev_addr = coeff_addr;
    end
  end

  // ---------------- per-cycle compare ----------------
  int               cyc = 0;
  bit               run_active = 1'b0;
  bit               run_done = 1'b0;
  int               start_cyc = 0;
  int               exp_done_cyc = 0;
  model_t           exp_r;
  logic [WIDTH-1:0] last_dst = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      int n;
      @(negedge clk);
      if (run_active) begin
        n = cyc - start_cyc;
        check("done", 32'(done), 32'(n == exp_done_cyc));
        check("busy", 32'(busy), 32'(n >= 1 && n < exp_done_cyc));
        if (n == 1) check("sat_clear_on_start", 32'(sat_flag), 32'd0);
        if (n == exp_done_cyc) begin
          check("dst", 32'(dst), 32'(exp_r.y));
          check("sat_flag", 32'(sat_flag), 32'(exp_r.sat));
          for (int i = 0; i <= ORDER; i++) begin
            check("addr_order", (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFF,
                  32'(ORDER - i));
          end
          last_dst   = exp_r.y;
          run_active = 1'b0;
          run_done   = 1'b1;
        end
      end else begin
        check("idle_no_done", 32'(done), 32'd0);
        check("dst_hold", 32'(dst), 32'(last_dst));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run(input string name, input logic [WIDTH-1:0] c2, input logic [WIDTH-1:0] c1,
                     input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] x,
                     input int wait_cyc, input bit stray_en, input int done_lit,
                     input logic [WIDTH-1:0] dst_lit, input bit sat_lit);
    model_t           m;
    logic [WIDTH-1:0] cv [0:ORDER];
    cv[0] = c0;
    cv[1] = c1;
    cv[2] = c2;
    m = poly_model(cv, x);
    check({name, "_model_dst"}, 32'(m.y), 32'(dst_lit));
    check({name, "_model_sat"}, 32'(m.sat), 32'(sat_lit));
    mem          = cv;
    mem_wait     = wait_cyc;
    stray        = stray_en;
    addr_log.delete();
    exp_r        = m;
    exp_done_cyc = done_lit;
    start_cyc    = cyc;
    run_done     = 1'b0;
    run_active   = 1'b1;
    start        = 1'b1;
    a2d          = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    a2d   = 16'h5A5A;
    for (int i = 0; i < 100 && !run_done; i++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_completed"}, 32'(run_done), 32'd1);
    run_active = 1'b0;
    stray      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coeff_req"}, 32'(coeff_req), 32'd0);
    check({tag, "_coeff_addr"}, 32'(coeff_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dst"}, 32'(dst), 32'd0);
    check({tag, "_sat_flag"}, 32'(sat_flag), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // name, c2, c1, c0, x, wait, stray, done cycle, dst, sat
    run("nominal", 16'h0000, 16'h1000, 16'h0010, 16'h0100, 1, 1'b0, 11, 16'h0110, 1'b0);
    run("pos_sat", 16'h0000, 16'h7000, 16'h7000, 16'h7FFF, 1, 1'b0, 11, 16'h7FFF, 1'b1);
    run("neg_sat", 16'h0000, 16'h1000, 16'h8000, 16'hFFFF, 1, 1'b0, 11, 16'h8000, 1'b1);
    run("wait3", 16'h0000, 16'h1000, 16'h0010, 16'h0100, 3, 1'b1, 17, 16'h0110, 1'b0);

    // Start again mid-run, then abort with reset.
    mem[0] = 16'h0010;
    mem[1] = 16'h1000;
    mem[2] = 16'h0000;
    mem_wait = 1;
    start    = 1'b1;               // cycle 0
    a2d      = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;                  // cycle 1
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1;                  // cycle 5 (MULT)
    a2d   = 16'h7FFF;
    @(posedge clk); #1;
    start = 1'b0;                  // cycle 6 (ADD)
    @(negedge clk);
    check("restart_ignored_addr", 32'(coeff_addr), 32'd1);
    check("restart_ignored_req", 32'(coeff_req), 32'd0);
    check("restart_ignored_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n    = 1'b0;               // cycle 7
    last_dst = '0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; end

    run("post_reset", 16'h0000, 16'h1000, 16'h0010, 16'h0100, 1, 1'b0, 11, 16'h0110, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_cal_datapath.md
# poly_cal_datapath

Parametrised successor to the single-step calibration datapath. Evaluates a signed fixed-point calibration polynomial on one A2D sample by Horner's rule. It uses one saturating multiplier, one saturating adder and a working Temp register, and is driven by an internal sequencer. Coefficients are fetched from NV memory over a req/vld handshake. The block sits between the A2D interface and the downstream result consumer.

## Interface
- WIDTH, 16: datapath width; all operands signed two's complement.
- FRAC, 12: fractional bits of coefficients (Q(WIDTH-FRAC).FRAC); samples are integers.
- ORDER, 2: polynomial order, ≥1; coefficients c[0..ORDER] are read at NV addresses 0..ORDER.
- AW, 4: coefficient address width; 2^AW > ORDER.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin evaluation; sampled only in IDLE
- a2d  in  WIDTH  sample x; latched into X register on accepted start
- coeff_req  out  1  coefficient read request
- coeff_addr  out  AW  address of requested coefficient
- coeff_vld  in  1  coeff valid; acknowledges the current request
- coeff  in  WIDTH  coefficient data, sampled when coeff_vld=1 and coeff_req=1
- busy  out  1  high from the cycle after an accepted start through the final ADD cycle
- done  out  1  one-cycle pulse; dst is valid
- dst  out  WIDTH  result register; holds until the next done
- sat_flag  out  1  sticky; any saturation during the current run

## Operation
- Function: p = c[ORDER]; then for k = ORDER-1 down to 0: p = satAdd(satMult(p, x), c[k]); dst = p.
- satMult: full 2·WIDTH signed product, arithmetic shift right FRAC, clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- satAdd: WIDTH+1-bit signed sum, clamped to the same range.
- Either clamp firing sets sat_flag. sat_flag clears on an accepted start.
- FSM states:
  - IDLE: start → FETCH, addr=ORDER, X←a2d, sat_flag←0.
  - FETCH: req=1, addr stable. On vld, C←coeff. If addr==ORDER, Temp←C and go to FETCH with addr−1. Otherwise go to MULT.
  - MULT: Temp←satMult(Temp,X) → ADD.
  - ADD: Temp←satAdd(Temp,C). If addr==0 → DONE. Otherwise go to FETCH with addr−1.
  - DONE: dst←Temp, done=1 → IDLE.
- start while busy or in DONE: ignored, with no effect on X or flags.
- coeff_vld while coeff_req=0: ignored.
- Reset values: coeff_req=0, coeff_addr=0, busy=0, done=0, dst=0, sat_flag=0. FSM, X, C and Temp all reset to IDLE/0.
- rst_n asserted mid-run aborts immediately. No done is produced, and the in-flight request is dropped.

## Timing
- Cycle 0: start sampled high in IDLE.
- coeff_req rises in the first FETCH cycle and stays high, with coeff_addr stable, up to and including the vld cycle. It drops in the following cycle.
- Memory returns coeff_vld at least 1 cycle after coeff_req rises, so each FETCH takes at least 2 cycles.
- Zero-wait latency: final ADD in cycle 4·ORDER+2; done and new dst in cycle 4·ORDER+3. For ORDER=2 that is cycle 11.
- Each extra wait cycle on coeff_vld adds exactly one cycle of latency.
- The next start is accepted in the cycle after done, giving back-to-back runs.

## Structure
- Package poly_cal_pkg holds:
  - state_t enum (IDLE, FETCH, MULT, ADD, DONE);
  - parametrised sat_add and sat_mult functions;
  - constants SAT_MAX and SAT_MIN as functions of WIDTH.
- Sub-module sat_alu_p (combinational): takes a, b and op (add/mult), and outputs y and sat. Instantiated once, shared by the MULT and ADD states.
- The FSM, X, C, Temp and dst registers live in poly_cal_datapath.

## Test plan
Common setup for all scenarios: WIDTH=16, FRAC=12, ORDER=2, zero-wait memory. Coefficients are listed as c2, c1, c0.

- **Nominal:** c=0x0000, 0x1000, 0x0010; a2d=0x0100.
  - dst=0x0110 with done in cycle 11.
  - sat_flag=0.
  - Addresses requested in order 2, 1, 0.
- **Positive saturation:** c=0x0000, 0x7000, 0x7000; a2d=0x7FFF.
  - dst=0x7FFF, sat_flag=1.
- **Negative saturation:** c=0x0000, 0x1000, 0x8000; a2d=0xFFFF.
  - dst=0x8000, sat_flag=1.
  - sat_flag clears when the next start is accepted.
- **Wait states:** coeff_vld delayed to 3 cycles after each req rise; nominal values.
  - done in cycle 17, dst=0x0110.
  - coeff_addr stable while req is high.
  - Stray vld pulses while req=0 are ignored.
- **Reset and start while busy:** pulse start again in cycle 5; then drop rst_n in cycle 7.
  - The second start has no effect.
  - After reset: all outputs are 0 and no done is produced.
  - A fresh start then gives the nominal result in cycle 11.
